serial_pattern_feeder: RTL and testbench



---
 rtl/lab3_pkg.sv | 15 +
 rtl/serial_pattern_feeder_if.sv | 31 +++
 rtl/btn_debounce.sv | 73 +++++++
 rtl/serial_pattern_feeder.sv | 100 ++++++++++
 tb/tb_serial_pattern_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lab3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab3_pkg
// Purpose  : Shared types and constants for the Lab3 serial pattern feeder.
// Revision : 1.0 - initial release
// ============================================================================
package lab3_pkg;

   typedef enum logic [1:0] {FEED_IDLE, FEED_SHIFT, FEED_DONE} feed_state_t;

   localparam int c_WIDTH_DEF  = 8;
   localparam int c_DB_CNT_SIM = 4;

endpackage
`default_nettype wire

// File: rtl/serial_pattern_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_feeder_if
// Purpose  : Switch/button inputs and serial bit stream of the pattern feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_pattern_feeder_if #(
   parameter int WIDTH = lab3_pkg::c_WIDTH_DEF
);
   localparam int BW = $clog2(WIDTH + 1);

   logic             load;
   logic [WIDTH-1:0] pattern_in;
   logic             step_btn;
   logic             bit_out;
   logic             bit_valid;
   logic             busy;
   logic             done;
   logic [BW-1:0]    bits_left;

   modport master (
      output load, pattern_in, step_btn,
      input  bit_out, bit_valid, busy, done, bits_left
   );

   modport slave (
      input  load, pattern_in, step_btn,
      output bit_out, bit_valid, busy, done, bits_left
   );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-FF sync, optional debounce (STEP_DEBOUNCE_EN), rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DB_CNT = 4,
   parameter bit USE_DB = 1'b1
) (
   input  wire logic clk,
   input  wire logic rstn,
   input  wire logic i_btn,
   output logic      o_pulse
);

`ifdef STEP_DEBOUNCE_EN
   localparam bit c_DB_BUILD = 1'b1;
`else
   localparam bit c_DB_BUILD = 1'b0;
`endif

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_pulse;
   logic w_level;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= w_level;
         r_pulse <= w_level & ~r_prev;
      end
   end

   generate
      if (c_DB_BUILD && USE_DB && (DB_CNT > 0)) begin : g_db
         localparam int CW = $clog2(DB_CNT + 1);
         logic [CW-1:0] r_cnt;
         logic          r_level;

         // Level follows the synced input only after DB_CNT steady cycles.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_cnt   <= '0;
               r_level <= 1'b0;
            end else if (r_sync2 == r_level) begin
               r_cnt   <= '0;
            end else if (r_cnt == CW'(DB_CNT - 1)) begin
               r_cnt   <= '0;
               r_level <= r_sync2;
            end else begin
               r_cnt   <= r_cnt + CW'(1);
            end
         end

         assign w_level = r_level;
      end else begin : g_nodb
         assign w_level = r_sync2;
      end
   endgenerate

   assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/serial_pattern_feeder.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_feeder
// Purpose  : Loads a pattern and emits it MSB-first, one bit per step press.
//            Step debounce is built only when STEP_DEBOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_feeder import lab3_pkg::*; #(
   parameter int WIDTH  = c_WIDTH_DEF,
   parameter int DB_CNT = 1000000
) (
   input wire logic               clk,
   input wire logic               rstn,
   serial_pattern_feeder_if.slave bus
);

   localparam int BW = $clog2(WIDTH + 1);

   feed_state_t      r_state;
   feed_state_t      w_next;
   logic [WIDTH-1:0] r_shreg;
   logic [BW-1:0]    r_bits_left;
   logic             r_bit_out;
   logic             r_bit_valid;
   logic             w_step_pulse;
   logic             w_load_pulse;
   logic             w_busy;
   logic             w_done;

   btn_debounce #(.DB_CNT(DB_CNT), .USE_DB(1'b1)) u_step_db (
      .clk     (clk),
      .rstn    (rstn),
      .i_btn   (bus.step_btn),
      .o_pulse (w_step_pulse)
   );

   btn_debounce #(.DB_CNT(DB_CNT), .USE_DB(1'b0)) u_load_edge (
      .clk     (clk),
      .rstn    (rstn),
      .i_btn   (bus.load),
      .o_pulse (w_load_pulse)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= FEED_IDLE;
      else       r_state <= w_next;
   end

   // Load has priority over step in every state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         FEED_IDLE:  if (w_load_pulse) w_next = FEED_SHIFT;
         FEED_SHIFT: begin
            if (w_load_pulse)                              w_next = FEED_SHIFT;
            else if (w_step_pulse && (r_bits_left == BW'(1))) w_next = FEED_DONE;
         end
         FEED_DONE:  if (w_load_pulse) w_next = FEED_SHIFT;
         default:    w_next = FEED_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         FEED_SHIFT: w_busy = 1'b1;
         FEED_DONE:  w_done = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shreg     <= '0;
         r_bits_left <= '0;
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
      end else begin
         r_bit_valid <= 1'b0;
         if (w_load_pulse) begin
            r_shreg     <= bus.pattern_in;
            r_bits_left <= BW'(WIDTH);
         end else if (w_step_pulse && (r_state == FEED_SHIFT)) begin
            r_bit_out   <= r_shreg[WIDTH-1];
            r_shreg     <= r_shreg << 1;
            r_bits_left <= r_bits_left - BW'(1);
            r_bit_valid <= 1'b1;
         end
      end
   end

   assign bus.bit_out   = r_bit_out;
   assign bus.bit_valid = r_bit_valid;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.bits_left = r_bits_left;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_feeder
// Purpose  : Self-checking bench for serial_pattern_feeder (either build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_feeder;
   import lab3_pkg::*;

   localparam int W  = c_WIDTH_DEF;
   localparam int DB = c_DB_CNT_SIM;
`ifdef STEP_DEBOUNCE_EN
   localparam int LAT = 4 + DB;
`else
   localparam int LAT = 4;
`endif

   typedef struct {
      logic [W-1:0] pat;
      int           steps;
      logic         exp_busy;
      logic         exp_done;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   serial_pattern_feeder_if #(.WIDTH(W)) bus_if ();

   serial_pattern_feeder #(.WIDTH(W), .DB_CNT(DB)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           strobes = 0;
   int           last_strobe_cyc = 0;
   logic         exp_q[$];
   logic         exp_bit;
   logic [W-1:0] m_pat = '0;
   int           m_idx = 0;
   vec_t         vecs[6];

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every strobe must match the oldest expected bit.
   always @(negedge clk) begin
      if (bus_if.bit_valid === 1'b1) begin
         strobes++;
         last_strobe_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe: unexpected bit_valid (bit_out=%0b), required no strobe at cycle %0d",
                     bus_if.bit_out, cyc);
         end else begin
            exp_bit = exp_q.pop_front();
            if (bus_if.bit_out !== exp_bit) begin
               errors++;
               $display("FAIL bit_out: got %0b required %0b at cycle %0d", bus_if.bit_out, exp_bit, cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [W-1:0] p);
      bus_if.pattern_in = p;
      bus_if.load       = 1'b1;
      tick(6);
      bus_if.load       = 1'b0;
      bus_if.pattern_in = ~p;
      tick(4);
      m_pat = p;
      m_idx = 0;
   endtask

   task automatic press(input bit expect_bit);
      if (expect_bit) begin
         exp_q.push_back(m_pat[W-1-m_idx]);
         m_idx++;
      end
      bus_if.step_btn = 1'b1;
      tick(10);
      bus_if.step_btn = 1'b0;
      tick(10);
   endtask

   initial begin
      int s0;
      int raise_cyc;
      vecs[0] = '{8'hAB, 8, 1'b0, 1'b1};
      vecs[1] = '{8'h55, 3, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 5, 1'b1, 1'b0};
      vecs[4] = '{8'h81, 8, 1'b0, 1'b1};
      vecs[5] = '{8'h3C, 1, 1'b1, 1'b0};

      bus_if.load       = 1'b0;
      bus_if.step_btn   = 1'b0;
      bus_if.pattern_in = '0;
      tick(3);
      chk("rst_bit_out",   32'(bus_if.bit_out),   0);
      chk("rst_bit_valid", 32'(bus_if.bit_valid), 0);
      chk("rst_busy",      32'(bus_if.busy),      0);
      chk("rst_done",      32'(bus_if.done),      0);
      chk("rst_bits_left", 32'(bus_if.bits_left), 0);
      rstn = 1'b1;
      tick(2);

      repeat (3) press(1'b0);
      chk("idle_bits_left", 32'(bus_if.bits_left), 0);
      chk("idle_bit_out",   32'(bus_if.bit_out),   0);
      chk("idle_busy",      32'(bus_if.busy),      0);

      do_load(8'hAB);
      chk("ab_busy", 32'(bus_if.busy), 1);
      chk("ab_left0", 32'(bus_if.bits_left), W);
      for (int i = 0; i < W; i++) begin
         press(1'b1);
         chk("ab_left", 32'(bus_if.bits_left), 32'(W - i - 1));
      end
      chk("ab_drain", 32'(exp_q.size()), 0);
      chk("ab_done", 32'(bus_if.done), 1);
      chk("ab_busy_end", 32'(bus_if.busy), 0);

      repeat (3) press(1'b0);
      chk("done_hold", 32'(bus_if.done), 1);
      chk("done_left", 32'(bus_if.bits_left), 0);
      do_load(8'h55);
      chk("reload_busy", 32'(bus_if.busy), 1);
      chk("reload_left", 32'(bus_if.bits_left), W);
      repeat (4) press(1'b1);
      chk("reload_left4", 32'(bus_if.bits_left), 4);

      for (int v = 0; v < 6; v++) begin
         do_load(vecs[v].pat);
         chk("tbl_load_left", 32'(bus_if.bits_left), W);
         for (int s = 0; s < vecs[v].steps; s++) press(1'b1);
         chk("tbl_drain", 32'(exp_q.size()), 0);
         chk("tbl_busy", 32'(bus_if.busy), 32'(vecs[v].exp_busy));
         chk("tbl_done", 32'(bus_if.done), 32'(vecs[v].exp_done));
         chk("tbl_left", 32'(bus_if.bits_left), 32'(W - vecs[v].steps));
      end

      // Load and step raised together after two bits.
      do_load(8'hAB);
      repeat (2) press(1'b1);
      m_pat = 8'hC3;
      m_idx = 0;
`ifdef STEP_DEBOUNCE_EN
      exp_q.push_back(m_pat[W-1]);
      m_idx = 1;
`endif
      bus_if.pattern_in = 8'hC3;
      bus_if.load       = 1'b1;
      bus_if.step_btn   = 1'b1;
      tick(10);
      bus_if.load       = 1'b0;
      bus_if.step_btn   = 1'b0;
      tick(10);
      chk("simul_drain", 32'(exp_q.size()), 0);
      chk("simul_left", 32'(bus_if.bits_left), 32'(W - m_idx));
      press(1'b1);
      chk("simul_next_drain", 32'(exp_q.size()), 0);

      // Bouncing step: two 2-cycle glitches then a stable press.
      do_load(8'hAB);
      s0 = strobes;
`ifdef STEP_DEBOUNCE_EN
      exp_q.push_back(m_pat[W-1]); m_idx = 1;
`else
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(m_pat[W-1-k]);
         m_idx++;
      end
`endif
      for (int g = 0; g < 2; g++) begin
         bus_if.step_btn = 1'b1; tick(2);
         bus_if.step_btn = 1'b0; tick(2);
      end
      raise_cyc = cyc;
      bus_if.step_btn = 1'b1; tick(10);
      bus_if.step_btn = 1'b0; tick(10);
`ifdef STEP_DEBOUNCE_EN
      chk("glitch_strobes", 32'(strobes - s0), 1);
`else
      chk("glitch_strobes", 32'(strobes - s0), 3);
`endif
      chk("glitch_latency", 32'(last_strobe_cyc - raise_cyc), LAT);
      chk("glitch_left", 32'(bus_if.bits_left), 32'(W - m_idx));

      // Asynchronous reset in the middle of a shift.
      do_load(8'hAB);
      repeat (3) press(1'b1);
      chk("mid_drain", 32'(exp_q.size()), 0);
      #2 rstn = 1'b0;
      #1;
      chk("arst_bit_out",   32'(bus_if.bit_out),   0);
      chk("arst_bit_valid", 32'(bus_if.bit_valid), 0);
      chk("arst_busy",      32'(bus_if.busy),      0);
      chk("arst_done",      32'(bus_if.done),      0);
      chk("arst_bits_left", 32'(bus_if.bits_left), 0);
      tick(2);
      rstn = 1'b1;
      tick(2);
      repeat (2) press(1'b0);
      chk("post_rst_left", 32'(bus_if.bits_left), 0);
      chk("post_rst_busy", 32'(bus_if.busy), 0);
      chk("post_rst_bit_out", 32'(bus_if.bit_out), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete, required completion within time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
